// File: rtl/inst_mem_responder.sv
// Instruction-memory responder: accepts fetches into a 2-deep queue and answers each
// one after a fixed wait with the stored word, or with a NOP plus error for bad addresses.
module inst_mem_responder #(
  parameter logic [31:0] RESET       = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  localparam int unsigned AW         = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inst_mem_req,
  input  logic [31:0]   inst_mem_address,
  output logic          inst_mem_ready,
  output logic          inst_mem_is_valid,
  output logic [31:0]   inst_mem_read_data,
  output logic          inst_mem_error,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] fifo_addr [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  occ;
  logic [1:0]  occ_next;
  logic [31:0] mem [DEPTH_WORDS];

  logic        start;
  logic        fire;
  logic        push;
  logic [31:0] head;
  logic [29:0] word_off;
  logic [AW-1:0] idx;
  logic        bad;

  // Handshake, response timing and address decode of the queue head.
  always_comb begin
    push     = inst_mem_req && inst_mem_ready;
    start    = (state != WAIT) && (occ != 2'd0);
    fire     = (start && (LATENCY == 0)) || ((state == WAIT) && (cnt == 4'd0));
    head     = fifo_addr[rd_ptr];
    word_off = 30'((head - RESET) >> 2);
    idx      = word_off[AW-1:0];
    bad      = (head[1:0] != 2'b00) || (word_off >= 30'(DEPTH_WORDS));
    case ({push, fire})
      2'b10:   occ_next = occ + 2'd1;
      2'b01:   occ_next = occ - 2'd1;
      default: occ_next = occ;
    endcase
  end

  // Program-load port; untouched by reset so contents survive it.
  always_ff @(posedge clk) begin
    if (load_we) mem[load_addr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_addr[wr_ptr] <= inst_mem_address;
  end

  // Request engine: the edge that enters RESP pops the head and registers the response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      cnt                <= 4'd0;
      occ                <= 2'd0;
      wr_ptr             <= 1'b0;
      rd_ptr             <= 1'b0;
      inst_mem_ready     <= 1'b0;
      inst_mem_is_valid  <= 1'b0;
      inst_mem_error     <= 1'b0;
      inst_mem_read_data <= 32'h0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (fire) rd_ptr <= ~rd_ptr;
      occ               <= occ_next;
      inst_mem_ready    <= (occ_next < 2'd2);
      inst_mem_is_valid <= fire;
      inst_mem_error    <= fire && bad;
      if (fire) inst_mem_read_data <= bad ? NOP : mem[idx];
      case (state)
        IDLE, RESP: begin
          if (!start) begin
            state <= IDLE;
          end else if (LATENCY == 0) begin
            state <= RESP;
          end else begin
            state <= WAIT;
            cnt   <= 4'(LATENCY - 1);
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/inst_mem_responder.md
INST_MEM_RESPONDER -- requirements
Module: inst_mem_responder

Interface
REQ-001 The block SHALL have parameter RESET, default 32'h0000_0000, meaning the byte address that maps to word 0.
REQ-002 The block SHALL have parameter DEPTH_WORDS, default 1024 (power of two), meaning the number of 32-bit memory words; AW = log2(DEPTH_WORDS).
REQ-003 The block SHALL have parameter LATENCY, default 2 (legal 0..15), meaning the number of wait cycles inserted before each response.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset; clock and reset are named as elsewhere in the codebase.
REQ-005 The ports SHALL be, in order:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- inst_mem_req  in  1  fetch request strobe
- inst_mem_address  in  32  fetch byte address
- inst_mem_ready  out  1  request can be accepted
- inst_mem_is_valid  out  1  response valid, one-cycle pulse per request
- inst_mem_read_data  out  32  instruction word
- inst_mem_error  out  1  qualifies the current response as a fault
- load_we  in  1  program-load write enable
- load_addr  in  AW  program-load word index
- load_data  in  32  program-load word

Function
REQ-006 A request SHALL be accepted on a rising edge where inst_mem_req && inst_mem_ready; the address is pushed into a 2-entry FIFO.
REQ-007 inst_mem_ready SHALL be 1 when FIFO occupancy < 2; no same-cycle bypass (a pop does not raise ready in the same cycle).
REQ-008 The request engine SHALL have states IDLE, WAIT, RESP:
- IDLE -> WAIT when the FIFO is non-empty and LATENCY > 0; the wait counter loads LATENCY-1.
- IDLE -> RESP when the FIFO is non-empty and LATENCY == 0.
- WAIT decrements the counter; WAIT -> RESP when the counter == 0.
- RESP pops the head and asserts inst_mem_is_valid for exactly one cycle, then goes to IDLE, or directly to WAIT/RESP if the FIFO still holds a request.
REQ-009 For a request accepted at edge t into an empty FIFO with the engine idle, inst_mem_is_valid SHALL be high in cycle t+1+LATENCY.
REQ-010 Sustained throughput SHALL be one response per LATENCY+1 cycles; responses SHALL be returned in acceptance order.
REQ-011 Word index = (inst_mem_address - RESET) >> 2, using 32-bit wrap-around subtraction.
REQ-012 If inst_mem_address[1:0] != 0 or the word index >= DEPTH_WORDS, the response SHALL carry inst_mem_read_data = 32'h0000_0013 (NOP) and inst_mem_error = 1.
- Otherwise inst_mem_error = 0 and inst_mem_read_data = mem[index].
REQ-013 inst_mem_read_data SHALL hold its last response value while inst_mem_is_valid = 0; inst_mem_error SHALL be 0 whenever inst_mem_is_valid = 0.
REQ-014 load_we SHALL write load_data to mem[load_addr] on the rising edge; loads are accepted in any state, including during reset.
REQ-015 When a load and a response read target the same word on the same edge, the response SHALL return the old contents; the new value is visible from the next response onward.
REQ-016 Request acceptance and response pop SHALL both be handled correctly on the same edge; occupancy is unchanged in that case.

Reset
REQ-017 While reset = 1 at an edge:
- FIFO is flushed; the engine goes to IDLE; the wait counter clears.
- Outputs: inst_mem_is_valid = 0, inst_mem_error = 0, inst_mem_read_data = 32'h0, inst_mem_ready = 0.
REQ-018 inst_mem_ready SHALL rise on the first edge after reset deasserts.
REQ-019 Reset asserted mid-WAIT or mid-RESP SHALL drop all in-flight requests with no response issued.
REQ-020 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-021 Load mem[0]=32'h0301_0413 with LATENCY=2, then request address 32'h0 at edge t -> valid pulse at t+3 with data 32'h0301_0413, error=0.
REQ-022 Request 32'h0000_0002 -> valid with data 32'h0000_0013 and error=1; request address DEPTH_WORDS*4 -> same.
REQ-023 Hold inst_mem_req high with 3 addresses 0,4,8 -> ready drops after 2 accepts; responses arrive in order, spaced LATENCY+1 cycles apart.
REQ-024 LATENCY=0, back-to-back requests -> one valid per cycle; data tracks address with 1-cycle latency.
REQ-025 Assert reset during WAIT with 2 queued -> no valid pulse; outputs zero; after release, mem contents intact and a new fetch returns the preloaded word.
REQ-026 Load the word being responded to on the RESP edge -> the response returns the old word; a refetch returns the new word.
